// File: rtl/title_pkg.sv
// Shared types and constants for the animated title overlay.
package title_pkg;
  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
  localparam int COORD_W = 11;
  localparam int OFF_W   = 12;

  typedef enum logic [1:0] {IDLE, SLIDE, BLINK, SHOW} title_state_t;

  // Bitmap content as a closed-form pattern of the linear address; MSB is
  // always 0 so no stored pixel collides with the transparent code.
  function automatic logic [7:0] rom_byte(input logic [13:0] a);
    return {1'b0, a[6:0] ^ a[13:7]};
  endfunction
endpackage

// File: rtl/title_rom.sv
// Synchronous-read bitmap store for all animation frames; one clock of latency.
module title_rom import title_pkg::*; #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data
);
  always_ff @(posedge clk) data <= rom_byte(14'(addr));
endmodule

// File: rtl/animated_title.sv
// Animated title overlay: slide-in / blink / show FSM plus a 2-stage pixel path.
module animated_title import title_pkg::*; #(
  parameter int TOP_LEFT_X    = 170,
  parameter int TOP_LEFT_Y    = 10,
  parameter int WIDTH         = 60,
  parameter int HEIGHT        = 20,
  parameter int SCALE_SHIFT   = 2,
  parameter int FRAMES        = 4,
  parameter int FRAME_HOLD    = 8,
  parameter int SLIDE_STEP    = 4,
  parameter int BLINK_HOLD    = 15,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               visible,
  input  logic               startOfFrame,
  input  logic               start,
  output logic               drawingRequest,
  output logic [7:0]         titleRGB,
  output logic               busy
);
  localparam int DEPTH = FRAMES * HEIGHT * WIDTH;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  localparam logic signed [OFF_W-1:0] LEFT_X  = OFF_W'(TOP_LEFT_X);
  localparam logic signed [OFF_W-1:0] TOP_Y   = OFF_W'(TOP_LEFT_Y);
  localparam logic signed [OFF_W-1:0] START_Y = OFF_W'(TOP_LEFT_Y - (HEIGHT << SCALE_SHIFT));
  localparam logic signed [OFF_W-1:0] STEP_Y  = OFF_W'(SLIDE_STEP);
  localparam logic signed [OFF_W-1:0] BOX_W   = OFF_W'(WIDTH << SCALE_SHIFT);
  localparam logic signed [OFF_W-1:0] BOX_H   = OFF_W'(HEIGHT << SCALE_SHIFT);
  localparam logic [15:0]   BLINK_LAST = 16'(BLINK_HOLD - 1);
  localparam logic [15:0]   HOLD_LAST  = 16'(FRAME_HOLD - 1);
  localparam logic [7:0]    TOG_LAST   = 8'(BLINK_TOGGLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  title_state_t             state_q;
  logic signed [OFF_W-1:0]  cur_y_q;
  logic [FW-1:0]            frame_q;
  logic                     blank_q, busy_q;
  logic [15:0]              cnt_q;
  logic [7:0]               tog_q;
  logic signed [OFF_W-1:0]  y_step;

  assign y_step = cur_y_q + STEP_Y;

  // All animation state moves only on startOfFrame (apart from launch) so a frame never tears.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cur_y_q <= TOP_Y;
      frame_q <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tog_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SLIDE;
          busy_q  <= 1'b1;
          cur_y_q <= START_Y;
          frame_q <= '0;
          blank_q <= 1'b0;
          cnt_q   <= '0;
          tog_q   <= '0;
        end
        SLIDE: if (startOfFrame) begin
          if (y_step >= TOP_Y) begin
            cur_y_q <= TOP_Y;
            state_q <= BLINK;
            cnt_q   <= '0;
          end else begin
            cur_y_q <= y_step;
          end
        end
        BLINK: if (startOfFrame) begin
          if (cnt_q == BLINK_LAST) begin
            cnt_q <= '0;
            tog_q <= tog_q + 8'd1;
            if (tog_q == TOG_LAST) begin
              state_q <= SHOW;
              blank_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              blank_q <= ~blank_q;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHOW: if (startOfFrame) begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            frame_q <= (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic signed [OFF_W-1:0] off_x, off_y;
  logic [OFF_W-1:0]        src_x, src_y;
  logic                    inside_d, inside_q, hit_q;
  logic [AW-1:0]           addr_d, addr_q;
  logic [7:0]              rom_data;

  assign off_x = $signed({1'b0, pixelX}) - LEFT_X;
  assign off_y = $signed({1'b0, pixelY}) - cur_y_q;
  assign src_x = OFF_W'($unsigned(off_x) >> SCALE_SHIFT);
  assign src_y = OFF_W'($unsigned(off_y) >> SCALE_SHIFT);

  // Negative offsets (left of box or rows still above the screen) fail the sign test.
  assign inside_d = visible && (state_q != IDLE) && !blank_q &&
                    !off_x[OFF_W-1] && (off_x < BOX_W) &&
                    !off_y[OFF_W-1] && (off_y < BOX_H);
  assign addr_d   = AW'((int'(frame_q) * HEIGHT + int'(src_y)) * WIDTH + int'(src_x));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inside_q <= 1'b0;
      addr_q   <= '0;
      hit_q    <= 1'b0;
    end else begin
      inside_q <= inside_d;
      addr_q   <= addr_d;
      hit_q    <= inside_q;
    end
  end

  title_rom #(.AW(AW)) u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (rom_data)
  );

  assign titleRGB       = hit_q ? rom_data : TRANSPARENT_ENCODING;
  assign drawingRequest = (titleRGB != TRANSPARENT_ENCODING);
  assign busy           = busy_q;
endmodule

// File: tb/tb_animated_title.sv
// Bench for animated_title: scoreboarded pixel probes across slide, blink, show and resets.
module tb_animated_title;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        visible = 1'b0, startOfFrame = 1'b0, start = 1'b0;
  logic        drawingRequest, busy;
  logic [7:0]  titleRGB;

  int total = 0, bad = 0, cyc = 0;

  typedef struct {logic [7:0] exp; int due; string nm;} sb_t;
  typedef struct {int x; int y; bit vis; logic [7:0] exp; string nm;} vec_t;
  sb_t  q[$];
  sb_t  e;
  vec_t tbl[8];

  animated_title dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .visible(visible), .startOfFrame(startOfFrame), .start(start),
    .drawingRequest(drawingRequest), .titleRGB(titleRGB), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk(e.nm, 32'(titleRGB), 32'(e.exp));
      chk({e.nm, "_req"}, 32'(drawingRequest), 32'(e.exp != 8'hFF));
    end
  end

  // Bitmap content at default geometry (60x20 per frame).
  function automatic logic [7:0] rom_at(input int f, input int sy, input int sx);
    logic [13:0] a;
    a = 14'((f * 20 + sy) * 60 + sx);
    return {1'b0, a[6:0] ^ a[13:7]};
  endfunction

  function automatic logic [7:0] px(input int x, input int y, input bit vis,
                                    input int cy, input int fr, input bit shown);
    int ox, oy;
    ox = x - 170;
    oy = y - cy;
    if (!shown || !vis || ox < 0 || ox >= 240 || oy < 0 || oy >= 80) return 8'hFF;
    return rom_at(fr, oy >> 2, ox >> 2);
  endfunction

  task automatic probe(input int x, input int y, input bit vis, input logic [7:0] exp, input string nm);
    @(posedge clk); #1;
    pixelX = 11'(x); pixelY = 11'(y); visible = vis;
    q.push_back('{exp, cyc + 2, nm});
    @(posedge clk); #1;
    visible = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic sof(input bit st);
    @(posedge clk); #1;
    startOfFrame = 1'b1; start = st; visible = 1'b0;
    @(posedge clk); #1;
    startOfFrame = 1'b0; start = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic chk_busy(input string nm, input bit exp);
    @(negedge clk);
    chk(nm, 32'(busy), 32'(exp));
  endtask

  task automatic do_slide(input bit with_sof);
    int cy;
    if (with_sof) sof(1'b1); else pulse_start();
    cy = -70;
    chk_busy("slide_busy0", 1'b1);
    probe(170, 0, 1'b1, px(170, 0, 1'b1, cy, 0, 1'b1), "slide_start_row");
    for (int k = 1; k <= 20; k++) begin
      sof(1'b0);
      cy = (cy + 4 >= 10) ? 10 : cy + 4;
      probe(170, (cy < 0) ? 0 : cy, 1'b1, px(170, (cy < 0) ? 0 : cy, 1'b1, cy, 0, 1'b1), "slide_step");
      chk_busy("slide_busy", 1'b1);
    end
    probe(170, 10, 1'b1, rom_at(0, 0, 0), "slide_end");
    probe(170, 9, 1'b1, 8'hFF, "slide_no_overshoot");
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1; resetN = 1'b0;
    pixelX = 11'd174; pixelY = 11'd14; visible = 1'b1;
    @(negedge clk);
    chk({nm, "_rgb"}, 32'(titleRGB), 32'hFF);
    chk({nm, "_req"}, 32'(drawingRequest), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    @(posedge clk); #1; resetN = 1'b1; visible = 1'b0;
  endtask

  initial begin
    tbl[0] = '{174, 14, 1'b1, rom_at(0, 1, 1),  "scale_1_1"};
    tbl[1] = '{409, 10, 1'b1, rom_at(0, 0, 59), "last_col"};
    tbl[2] = '{410, 10, 1'b1, 8'hFF,            "past_right"};
    tbl[3] = '{174, 14, 1'b0, 8'hFF,            "not_visible"};
    tbl[4] = '{170, 89, 1'b1, rom_at(0, 19, 0), "last_row"};
    tbl[5] = '{170, 90, 1'b1, 8'hFF,            "past_bottom"};
    tbl[6] = '{169, 10, 1'b1, 8'hFF,            "left_of_box"};
    tbl[7] = '{173, 13, 1'b1, rom_at(0, 0, 0),  "scale_0_0"};

    repeat (3) @(posedge clk);
    do_reset("reset");
    for (int f = 0; f < 3; f++) begin
      sof(1'b0);
      probe(174, 14, 1'b1, 8'hFF, "idle_hidden");
      chk_busy("idle_busy", 1'b0);
    end

    do_slide(1'b1);

    for (int k = 1; k <= 90; k++) begin
      sof(1'b0);
      probe(170, 10, 1'b1, (((k / 15) % 2 == 1) && k < 90) ? 8'hFF : rom_at(0, 0, 0), "blink");
      chk_busy("blink_busy", k < 90);
    end

    for (int i = 0; i < 8; i++) probe(tbl[i].x, tbl[i].y, tbl[i].vis, tbl[i].exp, tbl[i].nm);

    pulse_start();
    chk_busy("show_start_ignored", 1'b0);
    probe(170, 10, 1'b1, rom_at(0, 0, 0), "show_after_start");

    for (int p = 1; p <= 33; p++) begin
      sof(1'b0);
      probe(170, 10, 1'b1, rom_at((p / 8) % 4, 0, 0), "anim");
    end

    do_reset("reset_show");
    do_slide(1'b0);
    for (int k = 1; k <= 20; k++) sof(1'b0);
    probe(170, 10, 1'b1, 8'hFF, "blink_mid");
    do_reset("reset_blink");
    probe(170, 10, 1'b1, 8'hFF, "post_reset_idle");
    do_slide(1'b0);

    repeat (4) @(posedge clk);
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
